// File: rtl/voice_allocator.sv
// Shares NUM_VOICES voices between MIDI note events: match/free/oldest-releasing/oldest-held allocation, release tails, stealing.
// Event to voice outputs in NUM_VOICES+2 cycles; ev_ready is low from acceptance until the FSM is back in IDLE.
module voice_allocator #(
   parameter int NUM_VOICES  = 16,
   parameter int RELEASE_LEN = 50,
   parameter int AGE_W       = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    tick,
   input  logic                    ev_valid,
   output logic                    ev_ready,
   input  logic                    ev_on,
   input  logic [6:0]              ev_note,
   input  logic [2:0]              ev_vel,
   output logic [NUM_VOICES-1:0]   voice_gate,
   output logic [NUM_VOICES-1:0]   voice_busy,
   output logic [NUM_VOICES*7-1:0] voice_note,
   output logic [NUM_VOICES*3-1:0] voice_vel,
   output logic [NUM_VOICES-1:0]   voice_retrig
);

   localparam int IDX_W = $clog2(NUM_VOICES);
   localparam int REL_W = (RELEASE_LEN < 1) ? 1 : $clog2(RELEASE_LEN + 1);
   localparam logic [REL_W-1:0] REL_INIT = REL_W'(RELEASE_LEN);
   localparam logic [AGE_W-1:0] AGE_MAX  = '1;

   typedef enum logic [1:0] {S_IDLE, S_SCAN, S_COMMIT} fsm_t;
   typedef enum logic [1:0] {V_FREE, V_HELD, V_REL} vst_t;

   fsm_t state_q, state_d;
   logic accept, commit, scan_last;

   logic             on_q;
   logic [6:0]       note_q;
   logic [2:0]       vel_q;
   logic [IDX_W-1:0] idx_q;

   logic             match_vld, free_vld, rel_vld, held_vld;
   logic [IDX_W-1:0] match_idx, free_idx, rel_idx, held_idx, tgt;
   logic [AGE_W-1:0] rel_age, held_age;

   vst_t             vstate [NUM_VOICES];
   logic [6:0]       vnote  [NUM_VOICES];
   logic [2:0]       vvel   [NUM_VOICES];
   logic [AGE_W-1:0] vage   [NUM_VOICES];
   logic [REL_W-1:0] vrel   [NUM_VOICES];
   logic [NUM_VOICES-1:0] retrig_q;

   assign accept    = ev_valid && ev_ready;
   assign commit    = (state_q == S_COMMIT);
   assign scan_last = (idx_q == IDX_W'(NUM_VOICES - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= S_IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      ev_ready = 1'b0;
      case (state_q)
         S_IDLE: begin
            ev_ready = 1'b1;
            if (ev_valid) state_d = S_SCAN;
         end
         S_SCAN:   if (scan_last) state_d = S_COMMIT;
         S_COMMIT: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // One voice inspected per SCAN cycle; strict '>' keeps the lowest index on age ties.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         on_q      <= 1'b0;
         note_q    <= '0;
         vel_q     <= '0;
         idx_q     <= '0;
         match_vld <= 1'b0;
         free_vld  <= 1'b0;
         rel_vld   <= 1'b0;
         held_vld  <= 1'b0;
         match_idx <= '0;
         free_idx  <= '0;
         rel_idx   <= '0;
         held_idx  <= '0;
         rel_age   <= '0;
         held_age  <= '0;
      end else if (accept) begin
         on_q      <= ev_on && (ev_vel != 3'd0);
         note_q    <= ev_note;
         vel_q     <= ev_vel;
         idx_q     <= '0;
         match_vld <= 1'b0;
         free_vld  <= 1'b0;
         rel_vld   <= 1'b0;
         held_vld  <= 1'b0;
      end else if (state_q == S_SCAN) begin
         idx_q <= idx_q + 1'b1;
         if (!match_vld && vstate[idx_q] != V_FREE && vnote[idx_q] == note_q) begin
            match_vld <= 1'b1;
            match_idx <= idx_q;
         end
         if (!free_vld && vstate[idx_q] == V_FREE) begin
            free_vld <= 1'b1;
            free_idx <= idx_q;
         end
         if (vstate[idx_q] == V_REL && (!rel_vld || vage[idx_q] > rel_age)) begin
            rel_vld <= 1'b1;
            rel_idx <= idx_q;
            rel_age <= vage[idx_q];
         end
         if (vstate[idx_q] == V_HELD && (!held_vld || vage[idx_q] > held_age)) begin
            held_vld <= 1'b1;
            held_idx <= idx_q;
            held_age <= vage[idx_q];
         end
      end
   end

   always_comb begin
      tgt = held_idx;
      if (match_vld)     tgt = match_idx;
      else if (free_vld) tgt = free_idx;
      else if (rel_vld)  tgt = rel_idx;
   end

   // Commit assignments come after the countdown so they win on the same voice.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         retrig_q <= '0;
         for (int k = 0; k < NUM_VOICES; k++) begin
            vstate[k] <= V_FREE;
            vnote[k]  <= '0;
            vvel[k]   <= '0;
            vage[k]   <= '0;
            vrel[k]   <= '0;
         end
      end else begin
         retrig_q <= '0;
         for (int k = 0; k < NUM_VOICES; k++) begin
            if (vstate[k] == V_REL && tick) begin
               vrel[k] <= vrel[k] - 1'b1;
               if (vrel[k] <= REL_W'(1)) vstate[k] <= V_FREE;
            end
            if (commit) begin
               if (on_q) begin
                  if (IDX_W'(k) == tgt) begin
                     vstate[k]   <= V_HELD;
                     vnote[k]    <= note_q;
                     vvel[k]     <= vel_q;
                     vage[k]     <= '0;
                     vrel[k]     <= '0;
                     retrig_q[k] <= 1'b1;
                  end else if (vstate[k] != V_FREE && vage[k] != AGE_MAX) begin
                     vage[k] <= vage[k] + 1'b1;
                  end
               end else if (match_vld && IDX_W'(k) == match_idx && vstate[k] == V_HELD) begin
                  if (RELEASE_LEN == 0) begin
                     vstate[k] <= V_FREE;
                  end else begin
                     vstate[k] <= V_REL;
                     vrel[k]   <= REL_INIT;
                  end
               end
            end
         end
      end
   end

   always_comb begin
      voice_gate = '0;
      voice_busy = '0;
      voice_note = '0;
      voice_vel  = '0;
      for (int k = 0; k < NUM_VOICES; k++) begin
         voice_gate[k]        = (vstate[k] == V_HELD);
         voice_busy[k]        = (vstate[k] != V_FREE);
         voice_note[7*k +: 7] = vnote[k];
         voice_vel[3*k +: 3]  = vvel[k];
      end
   end

   assign voice_retrig = retrig_q;

endmodule
